// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling with a 16-bit bit timer,
// optional even parity, and sticky data/parity/framing status of the last completed frame.
module uart_rx #(
   parameter int CLOCK_RATE     = 50000000,
   parameter int BAUD_RATE      = 9600,
   parameter int DATA_BITS      = 8,
   parameter int PARITY_EN      = 1,
   parameter int CYCLES_PER_BIT = (CLOCK_RATE / BAUD_RATE) - 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_parity_err,
   output logic                 o_frame_err
);

   localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [15:0]       TERM_CNT = 16'(CYCLES_PER_BIT);
   localparam logic [15:0]       HALF_CNT = 16'(CYCLES_PER_BIT / 2);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   // Even parity: data bits plus parity bit must XOR to zero.
   function automatic logic f_parity_err(input logic [DATA_BITS-1:0] data, input logic par_bit);
      return (^data) ^ par_bit;
   endfunction

   logic                 r_rx_meta;
   logic                 r_rx_s;
   state_t               r_state;
   logic [15:0]          r_timer;
   logic [IDX_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic                 w_tick;

   assign w_tick = (r_timer == TERM_CNT);

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Receive FSM with bit timer, shift register and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_timer      <= 16'd0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_busy       <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_timer   <= 16'd0;
               r_bit_idx <= '0;
               if (!r_rx_s) begin
                  r_state <= ST_START;
                  o_busy  <= 1'b1;
               end
            end
            // Half a bit into the start bit: still low means a real frame.
            ST_START: begin
               if (r_timer == HALF_CNT) begin
                  r_timer <= 16'd0;
                  if (!r_rx_s) begin
                     r_state <= ST_DATA;
                  end else begin
                     r_state <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_timer <= 16'd0;
                  r_shift <= {r_rx_s, r_shift} >> 1;
                  if (r_bit_idx == LAST_IDX) begin
                     r_bit_idx <= '0;
                     r_state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_timer   <= 16'd0;
                  r_par_bit <= r_rx_s;
                  r_state   <= ST_STOP;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            // A low stop bit may be a break; wait for the line to go high before rearming.
            ST_STOP: begin
               if (w_tick) begin
                  r_timer      <= 16'd0;
                  o_data       <= r_shift;
                  o_parity_err <= (PARITY_EN != 0) ? f_parity_err(r_shift, r_par_bit) : 1'b0;
                  o_frame_err  <= ~r_rx_s;
                  o_valid      <= 1'b1;
                  if (r_rx_s) begin
                     r_state <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_WAIT_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_WAIT_IDLE: begin
               r_timer <= 16'd0;
               if (r_rx_s) begin
                  r_state <= ST_IDLE;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_timer <= 16'd0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit, 8 data bits, even parity.
module tb_uart_rx;

   localparam int CLOCK_RATE = 1000000;
   localparam int BAUD_RATE  = 100000;
   localparam int DATA_BITS  = 8;
   localparam int PARITY_EN  = 1;
   localparam int BIT_CLKS   = 10;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_busy;
   logic       o_parity_err;
   logic       o_frame_err;

   uart_rx #(
      .CLOCK_RATE (CLOCK_RATE),
      .BAUD_RATE  (BAUD_RATE),
      .DATA_BITS  (DATA_BITS),
      .PARITY_EN  (PARITY_EN)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_rx         (i_rx),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_busy       (o_busy),
      .o_parity_err (o_parity_err),
      .o_frame_err  (o_frame_err)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         fall_cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] vq[$];
   int         cq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Each cycle o_valid is high is logged, so a wider pulse shows up as extra entries.
   always @(negedge clk) begin
      if (o_valid) begin
         vq.push_back(o_data);
         cq.push_back(cyc);
      end
   end

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop_b;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      i_rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      fall_cyc = cyc;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
      drive_bit(p, BIT_CLKS);
      drive_bit(s, BIT_CLKS);
   endtask

   initial begin
      int n0;
      int lat;
      logic [7:0] d;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[3] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};

      i_rx    = 1'b1;
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);
      check("rst_data",  {24'd0, o_data}, 32'h00);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_busy",  {31'd0, o_busy}, 32'd0);
      check("rst_perr",  {31'd0, o_parity_err}, 32'd0);
      check("rst_ferr",  {31'd0, o_frame_err}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         n0 = vq.size();
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop_b);
         drive_bit(1'b1, BIT_CLKS);
         check($sformatf("v%0d_valid_cnt", i), vq.size() - n0, 32'd1);
         check($sformatf("v%0d_data", i), {24'd0, o_data}, {24'd0, vecs[i].exp_data});
         check($sformatf("v%0d_perr", i), {31'd0, o_parity_err}, {31'd0, vecs[i].exp_perr});
         check($sformatf("v%0d_ferr", i), {31'd0, o_frame_err}, {31'd0, vecs[i].exp_ferr});
         check($sformatf("v%0d_busy", i), {31'd0, o_busy}, 32'd0);
         lat = (vq.size() > n0) ? cq[n0] - fall_cyc : 0;
         checks++;
         if (lat < 107 || lat > 109) begin
            errors++;
            $display("FAIL v%0d_latency actual=%0d required=107..109", i, lat);
         end
      end

      // False start: 3 clocks low, then high.
      n0 = vq.size();
      drive_bit(1'b0, 3);
      check("fs_busy_hi", {31'd0, o_busy}, 32'd1);
      drive_bit(1'b1, 6);
      check("fs_busy_lo", {31'd0, o_busy}, 32'd0);
      drive_bit(1'b1, 20);
      check("fs_no_valid", vq.size() - n0, 32'd0);
      check("fs_data",     {24'd0, o_data}, 32'h7F);
      check("fs_perr",     {31'd0, o_parity_err}, 32'd1);
      check("fs_ferr",     {31'd0, o_frame_err}, 32'd0);

      // Framing error followed by a long break.
      n0 = vq.size();
      send_frame(8'h3C, 1'b0, 1'b0);
      drive_bit(1'b0, 50);
      check("fe_valid_cnt", vq.size() - n0, 32'd1);
      check("fe_data",      {24'd0, o_data}, 32'h3C);
      check("fe_ferr",      {31'd0, o_frame_err}, 32'd1);
      check("fe_perr",      {31'd0, o_parity_err}, 32'd0);
      check("fe_busy_hold", {31'd0, o_busy}, 32'd1);
      drive_bit(1'b1, BIT_CLKS);
      check("fe_busy_rel",  {31'd0, o_busy}, 32'd0);
      check("fe_no_second", vq.size() - n0, 32'd1);

      // Reset in the middle of data bit 4.
      n0 = vq.size();
      d  = 8'h5A;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
      drive_bit(d[4], 5);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      i_rx    = 1'b1;
      check("rm_data",  {24'd0, o_data}, 32'h00);
      check("rm_busy",  {31'd0, o_busy}, 32'd0);
      check("rm_ferr",  {31'd0, o_frame_err}, 32'd0);
      drive_bit(1'b1, 120);
      check("rm_no_valid", vq.size() - n0, 32'd0);
      send_frame(8'h5A, 1'b0, 1'b1);
      drive_bit(1'b1, BIT_CLKS);
      check("rm_valid_cnt", vq.size() - n0, 32'd1);
      check("rm_new_data",  {24'd0, o_data}, 32'h5A);
      check("rm_new_perr",  {31'd0, o_parity_err}, 32'd0);
      check("rm_new_ferr",  {31'd0, o_frame_err}, 32'd0);

      // Back-to-back frames with a single stop bit.
      n0 = vq.size();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      drive_bit(1'b1, BIT_CLKS);
      check("bb_valid_cnt", vq.size() - n0, 32'd2);
      if (vq.size() >= n0 + 2) begin
         check("bb_data0", {24'd0, vq[n0]}, 32'h00);
         check("bb_data1", {24'd0, vq[n0+1]}, 32'hFF);
         check("bb_spacing", cq[n0+1] - cq[n0], 32'd110);
      end else begin
         checks++;
         errors++;
         $display("FAIL bb_pulses actual=%0d required=2", vq.size() - n0);
      end
      check("bb_perr", {31'd0, o_parity_err}, 32'd0);
      check("bb_ferr", {31'd0, o_frame_err}, 32'd0);
      check("bb_busy", {31'd0, o_busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
